// File: rtl/cache_pkg.sv
`default_nettype none
//==== cache_pkg: shared widths, FSM encoding and word-select helper for data_cache ====
//==== rev 1.0 ====
package cache_pkg;
    localparam int TAG_W   = 25;
    localparam int IDX_W   = 3;
    localparam int OFS_W   = 2;
    localparam int WORD_W  = 32;
    localparam int BLOCK_W = 128;
    localparam int ADDR_W  = 30;
    localparam int MADDR_W = 28;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    function automatic logic [WORD_W-1:0] get_word(input logic [BLOCK_W-1:0] line,
                                                   input logic [OFS_W-1:0]   ofs);
        return line[ofs*WORD_W +: WORD_W];
    endfunction
endpackage
`default_nettype wire

// File: rtl/data_cache_if.sv
`default_nettype none
//==== data_cache_if: processor-side and memory-side signal bundle of the cache ====
//==== rev 1.0 ====
interface data_cache_if;
    import cache_pkg::*;

    logic                 proc_read;
    logic                 proc_write;
    logic [ADDR_W-1:0]    proc_addr;
    logic [WORD_W-1:0]    proc_wdata;
    logic                 proc_stall;
    logic [WORD_W-1:0]    proc_rdata;
    logic                 mem_read;
    logic                 mem_write;
    logic [MADDR_W-1:0]   mem_addr;
    logic [BLOCK_W-1:0]   mem_wdata;
    logic [BLOCK_W-1:0]   mem_rdata;
    logic                 mem_ready;

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/cache_array.sv
`default_nettype none
//==== cache_array: valid/dirty/tag/data storage, one read port and a fill/word write port ====
//==== rev 1.0 ====
module cache_array
    import cache_pkg::*;
#(
    parameter int NUM_BLOCKS = 8
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic [IDX_W-1:0]   idx,
    output logic                    rd_valid,
    output logic                    rd_dirty,
    output logic [TAG_W-1:0]        rd_tag,
    output logic [BLOCK_W-1:0]      rd_line,
    input  wire logic               fill_en,
    input  wire logic [TAG_W-1:0]   fill_tag,
    input  wire logic [BLOCK_W-1:0] fill_line,
    input  wire logic               word_en,
    input  wire logic [OFS_W-1:0]   word_ofs,
    input  wire logic [WORD_W-1:0]  word_data
);
    logic [NUM_BLOCKS-1:0] r_valid;
    logic [NUM_BLOCKS-1:0] r_dirty;
    logic [TAG_W-1:0]      r_tag  [NUM_BLOCKS];
    logic [BLOCK_W-1:0]    r_data [NUM_BLOCKS];

    assign rd_valid = r_valid[idx];
    assign rd_dirty = r_dirty[idx];
    assign rd_tag   = r_tag[idx];
    assign rd_line  = r_data[idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (fill_en) begin
            r_valid[idx] <= 1'b1;
            r_dirty[idx] <= 1'b0;
        end else if (word_en) begin
            r_dirty[idx] <= 1'b1;
        end
    end

    // Tag and data contents are meaningless until valid is set, so they carry no reset.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            r_tag[idx]  <= fill_tag;
            r_data[idx] <= fill_line;
        end else if (word_en) begin
            r_data[idx][word_ofs*WORD_W +: WORD_W] <= word_data;
        end
    end
endmodule
`default_nettype wire

// File: rtl/data_cache.sv
`default_nettype none
//==== data_cache: direct-mapped write-back write-allocate cache, zero-cycle hits ====
//==== rev 1.0 ====
module data_cache
    import cache_pkg::*;
#(
    parameter int NUM_BLOCKS      = 8,
    parameter int WORDS_PER_BLOCK = 4
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    data_cache_if.slave bus
);
    state_t r_state;
    state_t w_next;

    logic [IDX_W-1:0]   w_idx;
    logic [OFS_W-1:0]   w_ofs;
    logic [TAG_W-1:0]   w_tag;
    logic               w_req;
    logic               w_hit;
    logic               w_valid;
    logic               w_dirty;
    logic [TAG_W-1:0]   w_line_tag;
    logic [BLOCK_W-1:0] w_line;
    logic [WORD_W-1:0]  w_word;
    logic               w_fill_en;
    logic               w_word_en;

    assign w_ofs = bus.proc_addr[OFS_W-1:0];
    assign w_idx = bus.proc_addr[OFS_W +: IDX_W];
    assign w_tag = bus.proc_addr[ADDR_W-1 -: TAG_W];
    assign w_req = bus.proc_read | bus.proc_write;
    assign w_hit = w_valid && (w_line_tag == w_tag);

    always_comb begin
        w_word = '0;
        for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
            if (w_ofs == OFS_W'(k)) w_word = w_line[k*WORD_W +: WORD_W];
        end
    end

    cache_array #(
        .NUM_BLOCKS (NUM_BLOCKS)
    ) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .idx       (w_idx),
        .rd_valid  (w_valid),
        .rd_dirty  (w_dirty),
        .rd_tag    (w_line_tag),
        .rd_line   (w_line),
        .fill_en   (w_fill_en),
        .fill_tag  (w_tag),
        .fill_line (bus.mem_rdata),
        .word_en   (w_word_en),
        .word_ofs  (w_ofs),
        .word_data (bus.proc_wdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next          = r_state;
        bus.proc_stall  = 1'b0;
        bus.proc_rdata  = '0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        w_fill_en       = 1'b0;
        w_word_en       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (w_hit) begin
                        // A store wins when both request lines are high.
                        if (bus.proc_write) w_word_en      = 1'b1;
                        else                bus.proc_rdata = w_word;
                    end else begin
                        bus.proc_stall = 1'b1;
                        w_next = (w_valid && w_dirty) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                bus.proc_stall = 1'b1;
                bus.mem_write  = 1'b1;
                bus.mem_addr   = {w_line_tag, w_idx};
                bus.mem_wdata  = w_line;
                if (bus.mem_ready) w_next = ALLOCATE;
            end
            ALLOCATE: begin
                bus.proc_stall = 1'b1;
                bus.mem_read   = 1'b1;
                bus.mem_addr   = bus.proc_addr[ADDR_W-1:OFS_W];
                if (bus.mem_ready) begin
                    w_fill_en = 1'b1;
                    w_next    = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
        // Memory side goes quiet as soon as reset is seen, ahead of the state register.
        if (!rst_n) begin
            bus.mem_read  = 1'b0;
            bus.mem_write = 1'b0;
            bus.mem_addr  = '0;
            bus.mem_wdata = '0;
            if (!w_req) bus.proc_stall = 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
//==== tb_data_cache: directed self-checking bench for data_cache ====
//==== rev 1.0 ====
module tb_data_cache;
    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    data_cache_if bus();

    data_cache #(
        .NUM_BLOCKS      (8),
        .WORDS_PER_BLOCK (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Backing memory: word k of block b is {b, k, 2'b01}.
    function automatic logic [31:0] mem_word(input logic [27:0] b, input int k);
        logic [1:0] kk;
        kk = k[1:0];
        return {b, kk, 2'b01};
    endfunction

    function automatic logic [127:0] mem_line(input logic [27:0] b);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[k*32 +: 32] = mem_word(b, k);
        return l;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.proc_read  = rd;
        bus.proc_write = wr;
        bus.proc_addr  = a;
        bus.proc_wdata = d;
        bus.mem_ready  = 1'b0;
        #1;
    endtask

    // Holds off mem_ready for lat cycles of the transfer, checking the request stays up.
    task automatic serve(input logic is_wr, input logic [27:0] a, input logic [127:0] wd, input int lat);
        for (int c = 0; c < lat; c++) begin
            @(negedge clk);
            bus.mem_ready = (c == lat - 1);
            bus.mem_rdata = is_wr ? 128'h0 : mem_line(a);
            #1;
            check(is_wr ? "mem_write_held" : "mem_read_held",
                  is_wr ? bus.mem_write : bus.mem_read, 1);
            check("mem_rw_excl", bus.mem_read & bus.mem_write, 0);
            check("stall_xfer", bus.proc_stall, 1);
            if (c == 0) begin
                check(is_wr ? "wb_addr" : "fill_addr", bus.mem_addr, a);
                if (is_wr) check("wb_data", bus.mem_wdata, wd);
            end
        end
    endtask

    // Next cycle after a transfer: memory quiet, held request now served.
    task automatic settle;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
    endtask

    logic [127:0] victim;

    initial begin
        rst_n          = 1'b0;
        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b0;
        bus.proc_addr  = '0;
        bus.proc_wdata = '0;
        bus.mem_rdata  = '0;
        bus.mem_ready  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_read", bus.mem_read, 0);
        check("rst_mem_write", bus.mem_write, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_stall", bus.proc_stall, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Cold read of block 4
        drive(1, 0, 30'h0000_0010, 0);
        check("cold_stall", bus.proc_stall, 1);
        check("cold_idle_mem_read", bus.mem_read, 0);
        check("cold_rdata_zero", bus.proc_rdata, 0);
        serve(0, 28'h000_0004, 0, 3);
        settle();
        check("cold_hit_stall", bus.proc_stall, 0);
        check("cold_hit_rdata", bus.proc_rdata, mem_word(28'h4, 0));
        check("idle_mem_read", bus.mem_read, 0);
        check("idle_mem_wdata", bus.mem_wdata, 0);
        drive(1, 0, 30'h0000_0012, 0);
        check("hit_w2_stall", bus.proc_stall, 0);
        check("hit_w2_rdata", bus.proc_rdata, mem_word(28'h4, 2));

        // Write hit, then read it back
        drive(0, 1, 30'h0000_0011, 32'hDEAD_BEEF);
        check("wr_hit_stall", bus.proc_stall, 0);
        drive(1, 0, 30'h0000_0011, 0);
        check("rd_after_wr_stall", bus.proc_stall, 0);
        check("rd_after_wr_data", bus.proc_rdata, 32'hDEAD_BEEF);

        // Read and write together: the store takes effect
        drive(1, 1, 30'h0000_0013, 32'h1234_5678);
        check("both_stall", bus.proc_stall, 0);
        drive(1, 0, 30'h0000_0013, 0);
        check("both_store_won", bus.proc_rdata, 32'h1234_5678);

        // No request
        drive(0, 0, 30'h0000_0028, 0);
        check("noreq_stall", bus.proc_stall, 0);
        check("noreq_rdata", bus.proc_rdata, 0);

        // Write miss to index 2: clean allocate, then merge
        drive(0, 1, 30'h0000_0009, 32'hCAFE_F00D);
        check("wmiss_stall", bus.proc_stall, 1);
        serve(0, 28'h000_0002, 0, 1);
        settle();
        check("wmiss_merge_stall", bus.proc_stall, 0);
        drive(1, 0, 30'h0000_0008, 0);
        check("wmiss_w0", bus.proc_rdata, mem_word(28'h2, 0));
        drive(1, 0, 30'h0000_0009, 0);
        check("wmiss_w1", bus.proc_rdata, 32'hCAFE_F00D);
        drive(1, 0, 30'h0000_000A, 0);
        check("wmiss_w2", bus.proc_rdata, mem_word(28'h2, 2));
        drive(1, 0, 30'h0000_000B, 0);
        check("wmiss_w3", bus.proc_rdata, mem_word(28'h2, 3));

        // Dirty eviction at index 2 by tag 1
        victim = mem_line(28'h2);
        victim[63:32] = 32'hCAFE_F00D;
        drive(1, 0, 30'h0000_0028, 0);
        check("evict_stall", bus.proc_stall, 1);
        serve(1, 28'h000_0002, victim, 5);
        serve(0, 28'h000_000A, 0, 10);
        settle();
        check("evict_hit_stall", bus.proc_stall, 0);
        check("evict_hit_rdata", bus.proc_rdata, mem_word(28'hA, 0));

        // Reset in the middle of an allocate
        drive(1, 0, 30'h0000_0040, 0);
        @(negedge clk);
        #1;
        check("mid_alloc_read", bus.mem_read, 1);
        check("mid_alloc_addr", bus.mem_addr, 28'h000_0010);
        @(negedge clk);
        rst_n = 1'b0;
        bus.proc_read = 1'b0;
        @(negedge clk);
        #1;
        check("rst_abort_read", bus.mem_read, 0);
        check("rst_abort_write", bus.mem_write, 0);
        check("rst_abort_stall", bus.proc_stall, 0);
        rst_n = 1'b1;
        drive(1, 0, 30'h0000_0010, 0);
        check("reread_miss", bus.proc_stall, 1);
        serve(0, 28'h000_0004, 0, 2);
        settle();
        check("reread_hit_rdata", bus.proc_rdata, mem_word(28'h4, 0));

        drive(0, 0, 30'h0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL have parameter NUM_BLOCKS, 8, number of direct-mapped lines (power of 2).
REQ-002 SHALL have parameter WORDS_PER_BLOCK, 4, 32-bit words per line; fixed to match the 128-bit memory bus.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port proc_read  input  1  processor load request.
REQ-006 SHALL have port proc_write  input  1  processor store request.
REQ-007 SHALL have port proc_addr  input  30  word address; [1:0] word offset, [4:2] index, [29:5] tag.
REQ-008 SHALL have port proc_wdata  input  32  store data.
REQ-009 SHALL have port proc_stall  output  1  processor must hold its request and wait.
REQ-010 SHALL have port proc_rdata  output  32  load data, valid when proc_read=1 and proc_stall=0.
REQ-011 SHALL have port mem_read  output  1  line-fill request to slow memory.
REQ-012 SHALL have port mem_write  output  1  write-back request to slow memory.
REQ-013 SHALL have port mem_addr  output  28  block address, byte address bits [31:4].
REQ-014 SHALL have port mem_wdata  output  128  victim line; word 0 in bits [31:0].
REQ-015 SHALL have port mem_rdata  input  128  fill line; word 0 in bits [31:0].
REQ-016 SHALL have port mem_ready  input  1  one-cycle pulse completing the current memory read or write.

Function
REQ-017 SHALL be direct-mapped, write-back, write-allocate, with valid, dirty and 25-bit tag per line.
REQ-018 SHALL implement FSM states IDLE, WRITEBACK, ALLOCATE.
REQ-019 SHALL, in IDLE, treat a request as a hit when line valid and tag match; a hit drives proc_stall=0 combinationally in the same cycle (zero-cycle hit latency).
REQ-020 SHALL drive proc_rdata combinationally to the addressed word on a read hit, else 32'h0.
REQ-021 SHALL, on a write hit, write proc_wdata into the addressed word and set dirty at the clock edge.
REQ-022 SHALL, on a miss, assert proc_stall combinationally; the next state is WRITEBACK if the victim is valid and dirty, else ALLOCATE.
REQ-023 SHALL, in WRITEBACK, hold mem_write=1, mem_addr={victim tag, index} and mem_wdata=victim line until mem_ready, then go to ALLOCATE.
REQ-024 SHALL, in ALLOCATE, hold mem_read=1 and mem_addr=proc_addr[29:2] until mem_ready; on mem_ready, load mem_rdata, set valid=1, dirty=0, write the tag, and go to IDLE.
REQ-025 SHALL keep proc_stall=1 throughout WRITEBACK and ALLOCATE; the held request then hits in IDLE on the following cycle.
REQ-026 SHALL never assert mem_read and mem_write together; both are 0 in IDLE, and mem_addr/mem_wdata are 0 in IDLE.
REQ-027 SHALL give proc_write priority when proc_read and proc_write are both 1.
REQ-028 SHALL drive proc_stall=0 with no state change when no request is present.
REQ-029 SHALL ignore mem_ready while in IDLE.
REQ-030 SHALL rely on the processor holding proc_* stable while proc_stall=1; behaviour otherwise is undefined.

Reset
REQ-031 SHALL, when rst_n=0 at a clock edge, enter IDLE and clear all valid and dirty bits; data and tag arrays need not be cleared.
REQ-032 SHALL, on reset during WRITEBACK or ALLOCATE, abandon the transfer and drive mem_read=0 and mem_write=0 from the next cycle.
REQ-033 SHALL output, while in reset: mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, and proc_stall=0 when no request is present.

Structure
REQ-034 SHALL take the state enum, field widths (TAG_W=25, IDX_W=3, OFS_W=2) and block width (128) from shared package cache_pkg.
REQ-035 SHALL place tag/valid/dirty/data storage in one sub-module, cache_array; the FSM and hit logic stay in data_cache.

Verification
REQ-036 SHALL cover a cold read: after reset, read addr 30'h0000_0010 -> mem_read with mem_addr=28'h000_0004, fill, then a hit returning word 0 of the fill.
REQ-037 SHALL cover a write hit then read: write 32'hDEAD_BEEF to a resident word -> no stall, dirty=1; a read of the same word returns DEADBEEF with proc_stall=0.
REQ-038 SHALL cover a dirty eviction: a dirty line at index 2 plus a read with a different tag at index 2 -> mem_write with the old block address and line, then mem_read, never both high.
REQ-039 SHALL cover a write miss: store to an absent line -> clean allocate, then the store merges into the filled line; other words stay equal to memory.
REQ-040 SHALL cover reset mid-ALLOCATE: rst_n low while mem_read=1 -> mem_read=0 the next cycle, all lines invalid, and a re-read misses.
REQ-041 SHALL cover a variable memory latency of 1 to 10 cycles: mem_read/mem_write remain held until mem_ready, with no early exit.
